// File: rtl/axi_arbiter_w.sv
// Round-robin write-channel arbiter for a 4-master AXI interconnect.
// Holds one master's grant from AW through all W beats to B, and flags W burst-length mismatches.
module axi_arbiter_w (
    input  logic       ACLK,
    input  logic       ARESETn,
    input  logic       m0_AWVALID,
    input  logic       m1_AWVALID,
    input  logic       m2_AWVALID,
    input  logic       m3_AWVALID,
    input  logic       s_AWREADY,
    input  logic [7:0] m_AWLEN,
    input  logic       m_WVALID,
    input  logic       m_WLAST,
    input  logic       s_WREADY,
    input  logic       s_BVALID,
    input  logic       m_BREADY,
    output logic       m0_wgrnt,
    output logic       m1_wgrnt,
    output logic       m2_wgrnt,
    output logic       m3_wgrnt,
    output logic       w_phase,
    output logic       busy,
    output logic       wlast_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t     state, state_n;
    logic [1:0] owner, owner_n;
    logic [1:0] rr_ptr, rr_ptr_n;
    logic [7:0] len, len_n;
    logic [7:0] cnt, cnt_n;
    logic       err_n;

    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] win;
    logic       win_vld;
    logic [1:0] idx;
    logic       aw_hs, w_beat, b_hs;

    assign req    = {m3_AWVALID, m2_AWVALID, m1_AWVALID, m0_AWVALID};
    assign aw_hs  = req[owner] & s_AWREADY;
    assign w_beat = m_WVALID & s_WREADY;
    assign b_hs   = s_BVALID & m_BREADY;

    // Scan rr_ptr+1 .. rr_ptr+4 (mod 4); the last-serviced master ends up lowest priority.
    always_comb begin
        win     = rr_ptr;
        win_vld = 1'b0;
        idx     = '0;
        for (int unsigned i = 1; i <= 4; i++) begin
            idx = rr_ptr + 2'(i);
            if (!win_vld && req[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_n  = state;
        owner_n  = owner;
        rr_ptr_n = rr_ptr;
        len_n    = len;
        cnt_n    = cnt;
        err_n    = 1'b0;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    owner_n = win;
                    state_n = ADDR;
                end
            end
            ADDR: begin
                if (aw_hs) begin
                    len_n   = m_AWLEN;
                    cnt_n   = '0;
                    state_n = DATA;
                end
            end
            DATA: begin
                if (w_beat) begin
                    if (cnt != '1)
                        cnt_n = cnt + 8'd1;
                    // cnt is the index of the current beat; the closing beat must have index len.
                    if (m_WLAST) begin
                        err_n   = (cnt != len);
                        state_n = RESP;
                    end else begin
                        err_n = (cnt == len);
                    end
                end
            end
            RESP: begin
                if (b_hs) begin
                    rr_ptr_n = owner;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= 2'd3;
            len       <= '0;
            cnt       <= '0;
            wlast_err <= 1'b0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            rr_ptr    <= rr_ptr_n;
            len       <= len_n;
            cnt       <= cnt_n;
            wlast_err <= err_n;
        end
    end

    assign grant    = (state != IDLE) ? (4'b0001 << owner) : '0;
    assign m0_wgrnt = grant[0];
    assign m1_wgrnt = grant[1];
    assign m2_wgrnt = grant[2];
    assign m3_wgrnt = grant[3];
    assign w_phase  = (state == DATA);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_axi_arbiter_w.sv
// Directed self-checking bench for axi_arbiter_w: reset, single write, round-robin,
// WLAST early/late detection and asynchronous reset during a burst.
module tb_axi_arbiter_w;

    logic       ACLK = 1'b0;
    logic       ARESETn;
    logic [3:0] req;
    logic       s_AWREADY;
    logic [7:0] m_AWLEN;
    logic       m_WVALID, m_WLAST, s_WREADY, s_BVALID, m_BREADY;
    logic       m0_wgrnt, m1_wgrnt, m2_wgrnt, m3_wgrnt;
    logic       w_phase, busy, wlast_err;
    logic [3:0] gnt;

    int n_checks = 0;
    int n_fail   = 0;

    assign gnt = {m3_wgrnt, m2_wgrnt, m1_wgrnt, m0_wgrnt};

    always #5 ACLK = ~ACLK;

    axi_arbiter_w dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .m0_AWVALID (req[0]),
        .m1_AWVALID (req[1]),
        .m2_AWVALID (req[2]),
        .m3_AWVALID (req[3]),
        .s_AWREADY  (s_AWREADY),
        .m_AWLEN    (m_AWLEN),
        .m_WVALID   (m_WVALID),
        .m_WLAST    (m_WLAST),
        .s_WREADY   (s_WREADY),
        .s_BVALID   (s_BVALID),
        .m_BREADY   (m_BREADY),
        .m0_wgrnt   (m0_wgrnt),
        .m1_wgrnt   (m1_wgrnt),
        .m2_wgrnt   (m2_wgrnt),
        .m3_wgrnt   (m3_wgrnt),
        .w_phase    (w_phase),
        .busy       (busy),
        .wlast_err  (wlast_err)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Beat k (1-based) carries index k-1; closing beat must be index awlen, others must not reach it.
    function automatic logic exp_err(input int k, input int nb, input int awlen);
        if (k == nb) return ((k - 1) != awlen);
        return ((k - 1) == awlen);
    endfunction

    // Entered at a falling edge in IDLE with requests already driven on req.
    task automatic xfer(input int exp_m, input logic [7:0] awlen, input int nbeats,
                        input logic [3:0] mid_req);
        logic [3:0] eg;
        eg        = 4'(1 << exp_m);
        m_AWLEN   = awlen;
        s_AWREADY = 1'b1;
        @(negedge ACLK);
        chk4("addr_grant", gnt, eg);
        chk1("addr_busy", busy, 1'b1);
        chk1("addr_wphase", w_phase, 1'b0);
        m_WVALID = 1'b1;
        s_WREADY = 1'b1;
        m_WLAST  = 1'b0;
        @(negedge ACLK);
        s_AWREADY = 1'b0;
        req       = req | mid_req;
        for (int k = 1; k <= nbeats; k++) begin
            chk1("data_wphase", w_phase, 1'b1);
            chk4("data_grant", gnt, eg);
            if (k > 1) chk1("data_wlast_err", wlast_err, exp_err(k - 1, nbeats, int'(awlen)));
            else       chk1("data_wlast_err", wlast_err, 1'b0);
            m_WLAST = (k == nbeats);
            @(negedge ACLK);
        end
        chk1("resp_wphase", w_phase, 1'b0);
        chk4("resp_grant", gnt, eg);
        chk1("resp_wlast_err", wlast_err, exp_err(nbeats, nbeats, int'(awlen)));
        m_WVALID = 1'b0;
        m_WLAST  = 1'b0;
        s_BVALID = 1'b1;
        m_BREADY = 1'b1;
        @(negedge ACLK);
        chk4("idle_grant", gnt, 4'b0000);
        chk1("idle_busy", busy, 1'b0);
        chk1("idle_wlast_err", wlast_err, 1'b0);
        s_BVALID = 1'b0;
        m_BREADY = 1'b0;
    endtask

    initial begin
        ARESETn   = 1'b0;
        req       = '0;
        s_AWREADY = 1'b0;
        m_AWLEN   = '0;
        m_WVALID  = 1'b0;
        m_WLAST   = 1'b0;
        s_WREADY  = 1'b0;
        s_BVALID  = 1'b0;
        m_BREADY  = 1'b0;

        // Reset state
        repeat (3) @(negedge ACLK);
        chk4("rst_grant", gnt, 4'b0000);
        ARESETn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            chk4("post_rst_grant", gnt, 4'b0000);
            chk1("post_rst_busy", busy, 1'b0);
            chk1("post_rst_wphase", w_phase, 1'b0);
            chk1("post_rst_wlast_err", wlast_err, 1'b0);
        end

        // Round-robin with all requests held: order 0,1,2,3,0
        req = 4'b1111;
        xfer(0, 8'd0, 1, 4'b0000);
        xfer(1, 8'd0, 1, 4'b0000);
        xfer(2, 8'd0, 1, 4'b0000);
        xfer(3, 8'd0, 1, 4'b0000);
        xfer(0, 8'd0, 1, 4'b0000);
        req = 4'b0000;

        // Single write from m2, m0 arrives mid-transaction and must wait
        req = 4'b0100;
        xfer(2, 8'd3, 4, 4'b0001);
        // rr_ptr now 2: with m0 and m2 pending, m0 wins
        xfer(0, 8'd0, 1, 4'b0000);
        req = 4'b0000;

        // WLAST too late: AWLEN=1, WLAST on beat 3 -> pulses after beats 2 and 3
        req = 4'b1000;
        xfer(3, 8'd1, 3, 4'b0000);
        req = 4'b0000;

        // WLAST too early: AWLEN=3, WLAST on beat 2
        req = 4'b0010;
        xfer(1, 8'd3, 2, 4'b0000);
        req = 4'b0000;

        // Reset mid-burst with WREADY toggling (rr_ptr is 1 at this point)
        req       = 4'b0100;
        m_AWLEN   = 8'd3;
        s_AWREADY = 1'b1;
        @(negedge ACLK);
        chk4("mid_addr_grant", gnt, 4'b0100);
        m_WVALID = 1'b1;
        s_WREADY = 1'b0;
        @(negedge ACLK);
        s_AWREADY = 1'b0;
        req       = 4'b0000;
        chk1("mid_data_wphase", w_phase, 1'b1);
        for (int i = 0; i < 4; i++) begin
            s_WREADY = i[0];
            @(negedge ACLK);
        end
        chk1("mid_pre_rst_wphase", w_phase, 1'b1);
        #2 ARESETn = 1'b0;
        #1;
        chk4("async_rst_grant", gnt, 4'b0000);
        chk1("async_rst_wphase", w_phase, 1'b0);
        chk1("async_rst_busy", busy, 1'b0);
        chk1("async_rst_wlast_err", wlast_err, 1'b0);
        m_WVALID = 1'b0;
        s_WREADY = 1'b0;
        @(negedge ACLK);
        chk1("rst_hold_wlast_err", wlast_err, 1'b0);
        ARESETn = 1'b1;
        // m1 and m3 request together: reset rr_ptr=3 favours m1
        req = 4'b1010;
        xfer(1, 8'd0, 1, 4'b0000);
        req = 4'b0000;
        @(negedge ACLK);
        chk4("final_grant", gnt, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_arbiter_w.md
# axi_arbiter_w

Round-robin write-channel arbiter for the 4-master AXI interconnect: the write-side counterpart of the read arbiter. It selects one master from the AW requests and holds that master's grant across the whole write transaction: address handshake, all W beats, then the B response. It also checks the W burst length against AWLEN. It sits beside the AW/W/B muxes, which steer channels from the one-hot grant and gate the W channel with `w_phase`.

## Interface
Parameters: none; 4 masters and AXI4 8-bit AWLEN are fixed.
- ACLK  in  1  clock; all state changes on the rising edge
- ARESETn  in  1  reset, asynchronous, active-low
- m0_AWVALID..m3_AWVALID  in  1 each  raw AW request from each master, not muxed
- s_AWREADY  in  1  AWREADY from the addressed slave
- m_AWLEN  in  8  AWLEN of the granted master, muxed by grant
- m_WVALID  in  1  WVALID of the granted master, muxed
- m_WLAST  in  1  WLAST of the granted master, muxed
- s_WREADY  in  1  WREADY from the addressed slave
- s_BVALID  in  1  BVALID from the addressed slave
- m_BREADY  in  1  BREADY of the granted master, muxed
- m0_wgrnt..m3_wgrnt  out  1 each  one-hot write grant, registered
- w_phase  out  1  high only in DATA state; the mux ANDs it into WVALID/WREADY routing
- busy  out  1  high in any state except IDLE
- wlast_err  out  1  one-cycle pulse on a burst-length mismatch

## Operation
- **State register and reset.**
  - States: IDLE, ADDR, DATA, RESP (2-bit encoding).
  - Other registers: owner[1:0], rr_ptr[1:0] (last serviced master), len[7:0], cnt[7:0].
  - On reset:
    - state = IDLE, owner = 0, rr_ptr = 3, len = 0, cnt = 0.
    - All grants 0, w_phase 0, busy 0, wlast_err 0.
  - rr_ptr = 3 gives priority order 0>1>2>3 after reset.
- **IDLE.**
  - Grants are all 0.
  - If any mX_AWVALID is high, the winner is the first requester scanning rr_ptr+1, rr_ptr+2, rr_ptr+3, rr_ptr (mod 4).
  - On that edge: owner ← winner, state → ADDR.
  - If there are no requests, stay in IDLE.
- **ADDR.**
  - The grant for owner is high.
  - AW handshake = the owner's mX_AWVALID & s_AWREADY.
  - On the handshake: len ← m_AWLEN, cnt ← 0, state → DATA.
  - If the owner drops AWVALID (protocol violation), stay in ADDR. The grant is not revoked.
- **DATA.**
  - Grant held, w_phase = 1.
  - Beat = m_WVALID & s_WREADY. On each beat, cnt ← cnt+1, saturating at 255.
  - Beat with m_WLAST = 1:
    - state → RESP.
    - If cnt ≠ len, pulse wlast_err next cycle.
  - Beat with m_WLAST = 0 and cnt == len (too long):
    - Pulse wlast_err next cycle.
    - Stay in DATA until a WLAST beat. A second mismatch on the closing beat pulses again.
- **RESP.**
  - Grant held, w_phase = 0.
  - On s_BVALID & m_BREADY: rr_ptr ← owner, state → IDLE.
- **Outputs.**
  - Grants are a decode of owner qualified by state ≠ IDLE. Exactly one is high in ADDR/DATA/RESP.
  - wlast_err is a registered pulse, exactly 1 cycle per violation.

## Timing
- Grant latency:
  - Grant is high 1 cycle after the edge on which IDLE samples AWVALID.
  - The AW handshake can complete in that same first ADDR cycle.
- Minimum transaction for a 1-beat burst with all ready/valid high: 4 cycles (IDLE, ADDR, DATA, RESP).
- Grant deasserts the cycle after the B handshake. There is one IDLE cycle between consecutive transactions, even from the same master.
- w_phase rises the cycle after the AW handshake and falls the cycle after the WLAST beat. W beats presented during ADDR are not accepted (gated by the mux).
- Simultaneous requests are resolved in a single cycle by rotating priority. A newly arriving request never preempts a held grant.
- Reset mid-transaction:
  - Asynchronous return to reset values. The grant drops immediately.
  - No wlast_err is generated for the aborted burst.

## Test plan
- **Reset state.** Reset with all inputs 0, then release → all grants 0, busy 0, w_phase 0, wlast_err 0, held for 10 idle cycles.
- **Single write.** m2 single write, AWLEN=3, 4 beats with WLAST on beat 4, B ready → m2_wgrnt high from the cycle after AWVALID through the B handshake; w_phase high for exactly 4 cycles; wlast_err never pulses.
- **Round-robin.** All four AWVALIDs held high, 1-beat bursts → grant order 0,1,2,3,0. A request asserted mid-transaction does not change the current grant.
- **WLAST too early.** AWLEN=3, WLAST on beat 2 → wlast_err single pulse the cycle after beat 2; state → RESP; the B handshake returns to IDLE.
- **WLAST too late.** AWLEN=1, WLAST on beat 3 → wlast_err pulse after beat 2 (cnt==len without WLAST) and another after beat 3; grant held until B.
- **Reset mid-burst.** ARESETn pulsed low during DATA with backpressure (WREADY toggling) → grants and w_phase go to 0 asynchronously. The next request from m1 is granted first (rr_ptr = 3).
